// File: rtl/wb_pkg.sv
// Shared types and constants for the register file writeback path.
// wb_req_t is the default load-result entry; widths match the default arbiter build.
package wb_pkg;
    localparam int WB_ADDRESS_WIDTH = 5;
    localparam int WB_DATA_WIDTH    = 32;
    localparam int REG_X0           = 0;
    localparam int NUM_REGS         = 2 ** WB_ADDRESS_WIDTH;

    typedef struct packed {
        logic [WB_ADDRESS_WIDTH-1:0] rd;
        logic [WB_DATA_WIDTH-1:0]    data;
    } wb_req_t;
endpackage

// File: rtl/wb_port_arbiter_if.sv
// Writeback sources (ALU, load issue/return) and the regfile write port plus status.
// master = sources/regfile side, slave = the arbiter.
interface wb_port_arbiter_if #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int LD_FIFO_DEPTH = 2
);
    logic                             alu_valid;
    logic [ADDRESS_WIDTH-1:0]         alu_rd;
    logic [DATA_WIDTH-1:0]            alu_data;
    logic                             ld_issue;
    logic [ADDRESS_WIDTH-1:0]         ld_issue_rd;
    logic                             ld_valid;
    logic                             ld_ready;
    logic [ADDRESS_WIDTH-1:0]         ld_rd;
    logic [DATA_WIDTH-1:0]            ld_data;
    logic                             WE3;
    logic [ADDRESS_WIDTH-1:0]         AD3;
    logic [DATA_WIDTH-1:0]            WD3;
    logic [2**ADDRESS_WIDTH-1:0]      busy;
    logic [$clog2(LD_FIFO_DEPTH+1)-1:0] ld_cnt;

    modport master (
        output alu_valid, alu_rd, alu_data, ld_issue, ld_issue_rd,
               ld_valid, ld_rd, ld_data,
        input  ld_ready, WE3, AD3, WD3, busy, ld_cnt
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, ld_issue, ld_issue_rd,
               ld_valid, ld_rd, ld_data,
        output ld_ready, WE3, AD3, WD3, busy, ld_cnt
    );
endinterface

// File: rtl/wb_ld_fifo.sv
// Sync FIFO of writeback requests; head is visible combinationally, 1-cycle push-to-pop.
// Push is ignored when full and pop ignored when empty; caller gates push with !full.
module wb_ld_fifo
    import wb_pkg::*;
#(
    parameter type T     = wb_req_t,
    parameter int  DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  T              push_data,
    input  logic          pop,
    output T              head,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);
    T              mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/wb_port_arbiter.sv
// Regfile write-port arbiter: ALU has fixed priority, loads buffered in a FIFO; registered port, busy scoreboard.
// Loads see ld_ready = !full (no input path); ALU never stalled. WB_LD_BYPASS_EN: empty-FIFO load writes at the accept edge.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int LD_FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    wb_port_arbiter_if.slave  port
);
    localparam int CW = $clog2(LD_FIFO_DEPTH + 1);
    localparam int NR = 2 ** ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] X0 = ADDRESS_WIDTH'(REG_X0);

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]    data;
    } req_t;

    req_t                     push_req;
    req_t                     head;
    logic                     fifo_empty;
    logic                     fifo_full;
    logic [CW-1:0]            cnt;
    logic                     alu_sel;
    logic                     ld_take;
    logic                     byp;
    logic                     push;
    logic                     pop;
    logic                     ld_sel;
    logic [ADDRESS_WIDTH-1:0] ld_wr_rd;
    logic [DATA_WIDTH-1:0]    ld_wr_data;
    logic                     we_q;
    logic [ADDRESS_WIDTH-1:0] ad_q;
    logic [DATA_WIDTH-1:0]    wd_q;
    logic [NR-1:0]            busy_q;
    logic [NR-1:0]            busy_nxt;

    assign push_req = '{rd: port.ld_rd, data: port.ld_data};
    assign alu_sel  = port.alu_valid && (port.alu_rd != X0);
    // Loads to x0 complete the handshake but are otherwise discarded.
    assign ld_take  = port.ld_valid && !fifo_full && (port.ld_rd != X0);

`ifdef WB_LD_BYPASS_EN
    assign byp = ld_take && !alu_sel && fifo_empty;
`else
    assign byp = 1'b0;
`endif

    assign push       = ld_take && !byp;
    assign pop        = !alu_sel && !fifo_empty;
    assign ld_sel     = pop || byp;
    assign ld_wr_rd   = pop ? head.rd   : port.ld_rd;
    assign ld_wr_data = pop ? head.data : port.ld_data;

    wb_ld_fifo #(
        .T     (req_t),
        .DEPTH (LD_FIFO_DEPTH)
    ) u_ld_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_req),
        .pop       (pop),
        .head      (head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (cnt)
    );

    // Clear before set so an issue racing the writeback of the same register wins.
    always_comb begin
        busy_nxt = busy_q;
        if (ld_sel) begin
            busy_nxt[ld_wr_rd] = 1'b0;
        end
        if (port.ld_issue && (port.ld_issue_rd != X0)) begin
            busy_nxt[port.ld_issue_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q   <= 1'b0;
            ad_q   <= '0;
            wd_q   <= '0;
            busy_q <= '0;
        end else begin
            we_q   <= alu_sel || ld_sel;
            busy_q <= busy_nxt;
            if (alu_sel) begin
                ad_q <= port.alu_rd;
                wd_q <= port.alu_data;
            end else if (ld_sel) begin
                ad_q <= ld_wr_rd;
                wd_q <= ld_wr_data;
            end
        end
    end

    assign port.WE3      = we_q;
    assign port.AD3      = ad_q;
    assign port.WD3      = wd_q;
    assign port.busy     = busy_q;
    assign port.ld_cnt   = cnt;
    assign port.ld_ready = !fifo_full;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter (default build): ALU path, x0, contention, full FIFO, scoreboard race, async reset.
module tb_wb_port_arbiter;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int D  = 2;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    logic [DW-1:0] rf [2**AW];

    wb_port_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .LD_FIFO_DEPTH(D)) bus ();

    wb_port_arbiter #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .LD_FIFO_DEPTH (D)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .port  (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file model committing whatever the port presents.
    always @(posedge clk) begin
        if (bus.WE3) rf[bus.AD3] <= bus.WD3;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_valid   = 1'b0;
        bus.alu_rd      = '0;
        bus.alu_data    = '0;
        bus.ld_issue    = 1'b0;
        bus.ld_issue_rd = '0;
        bus.ld_valid    = 1'b0;
        bus.ld_rd       = '0;
        bus.ld_data     = '0;
    endtask

    task automatic alu(input logic [AW-1:0] rd, input logic [DW-1:0] d);
        bus.alu_valid = 1'b1;
        bus.alu_rd    = rd;
        bus.alu_data  = d;
    endtask

    task automatic ld(input logic [AW-1:0] rd, input logic [DW-1:0] d);
        bus.ld_valid = 1'b1;
        bus.ld_rd    = rd;
        bus.ld_data  = d;
    endtask

    task automatic port_chk(input string tag, input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
        check({tag, ".we"}, 64'(bus.WE3), 64'(we));
        check({tag, ".ad"}, 64'(bus.AD3), 64'(ad));
        check({tag, ".wd"}, 64'(bus.WD3), 64'(wd));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        idle();
        tick();
        tick();
        port_chk("rst", 1'b0, 5'd0, 32'd0);
        check("rst.busy", 64'(bus.busy), 64'd0);
        check("rst.cnt", 64'(bus.ld_cnt), 64'd0);
        rst_n = 1'b1;
        #1;
        check("rst.ready", 64'(bus.ld_ready), 64'd1);

        // ALU only
        alu(5'd5, 32'hDEADBEEF);
        tick();
        idle();
        port_chk("alu", 1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        check("alu.rf5", 64'(rf[5]), 64'hDEADBEEF);
        port_chk("alu.hold", 1'b0, 5'd5, 32'hDEADBEEF);

        // x0 suppression for both sources
        alu(5'd0, 32'h1);
        ld(5'd0, 32'h55);
        tick();
        idle();
        check("x0.we", 64'(bus.WE3), 64'd0);
        check("x0.cnt", 64'(bus.ld_cnt), 64'd0);
        check("x0.busy", 64'(bus.busy), 64'd0);
        tick();
        check("x0.we2", 64'(bus.WE3), 64'd0);

        // Contention: load to 7 waits behind three ALU writes
        bus.ld_issue    = 1'b1;
        bus.ld_issue_rd = 5'd7;
        tick();
        idle();
        check("cont.busy7", 64'(bus.busy), 64'h80);
        alu(5'd1, 32'h11);
        ld(5'd7, 32'h1234);
        tick();
        idle();
        port_chk("cont.w1", 1'b1, 5'd1, 32'h11);
        check("cont.cnt1", 64'(bus.ld_cnt), 64'd1);
        alu(5'd2, 32'h22);
        tick();
        port_chk("cont.w2", 1'b1, 5'd2, 32'h22);
        alu(5'd3, 32'h33);
        tick();
        idle();
        port_chk("cont.w3", 1'b1, 5'd3, 32'h33);
        check("cont.busy_held", 64'(bus.busy), 64'h80);
        tick();
        port_chk("cont.w7", 1'b1, 5'd7, 32'h1234);
        check("cont.busy_clr", 64'(bus.busy), 64'd0);
        check("cont.cnt0", 64'(bus.ld_cnt), 64'd0);

        // FIFO full under sustained ALU traffic
        alu(5'd1, 32'hA1);
        ld(5'd8, 32'h80);
        tick();
        check("full.cnt1", 64'(bus.ld_cnt), 64'd1);
        check("full.rdy1", 64'(bus.ld_ready), 64'd1);
        alu(5'd1, 32'hA2);
        ld(5'd9, 32'h90);
        tick();
        check("full.cnt2", 64'(bus.ld_cnt), 64'd2);
        check("full.rdy0", 64'(bus.ld_ready), 64'd0);
        alu(5'd1, 32'hA3);
        ld(5'd10, 32'hA0);
        tick();
        check("full.cnt_hold", 64'(bus.ld_cnt), 64'd2);
        port_chk("full.alu", 1'b1, 5'd1, 32'hA3);
        bus.alu_valid = 1'b0;
        tick();
        port_chk("full.w8", 1'b1, 5'd8, 32'h80);
        check("full.cnt_pop", 64'(bus.ld_cnt), 64'd1);
        check("full.rdy_back", 64'(bus.ld_ready), 64'd1);
        tick();
        idle();
        port_chk("full.w9", 1'b1, 5'd9, 32'h90);
        check("full.cnt_pushpop", 64'(bus.ld_cnt), 64'd1);
        tick();
        port_chk("full.w10", 1'b1, 5'd10, 32'hA0);
        check("full.cnt_empty", 64'(bus.ld_cnt), 64'd0);
        tick();
        check("full.rf10", 64'(rf[10]), 64'hA0);

        // Scoreboard race: re-issue to 9 on the edge its load is written
        bus.ld_issue    = 1'b1;
        bus.ld_issue_rd = 5'd9;
        tick();
        idle();
        check("race.set", 64'(bus.busy), 64'h200);
        ld(5'd9, 32'h99);
        tick();
        idle();
        bus.ld_issue    = 1'b1;
        bus.ld_issue_rd = 5'd9;
        tick();
        idle();
        port_chk("race.w9", 1'b1, 5'd9, 32'h99);
        check("race.busy9", 64'(bus.busy), 64'h200);
        ld(5'd9, 32'h9A);
        tick();
        idle();
        tick();
        port_chk("race.w9b", 1'b1, 5'd9, 32'h9A);
        check("race.clr", 64'(bus.busy), 64'd0);

        // Async reset with a full FIFO and an active write
        bus.ld_issue    = 1'b1;
        bus.ld_issue_rd = 5'd12;
        tick();
        idle();
        alu(5'd1, 32'hB1);
        ld(5'd12, 32'hC0);
        tick();
        alu(5'd2, 32'hB2);
        ld(5'd13, 32'hD0);
        tick();
        check("ar.pre_cnt", 64'(bus.ld_cnt), 64'd2);
        check("ar.pre_we", 64'(bus.WE3), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        port_chk("ar.rst", 1'b0, 5'd0, 32'd0);
        check("ar.cnt", 64'(bus.ld_cnt), 64'd0);
        check("ar.busy", 64'(bus.busy), 64'd0);
        idle();
        tick();
        rst_n = 1'b1;
        alu(5'd4, 32'h44);
        tick();
        idle();
        port_chk("ar.alu4", 1'b1, 5'd4, 32'h44);
        tick();
        check("ar.rf4", 64'(rf[4]), 64'h44);
        check("ar.idle_we", 64'(bus.WE3), 64'd0);
        check("ar.idle_cnt", 64'(bus.ld_cnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
